// File: rtl/eq_mixer.sv
// -----------------------------------------------------------------------------
// eq_mixer
//
// Stereo graphic-EQ mixer. A set of NUM_BANDS band samples per channel is
// weighted by per-band gains (POT), summed, and scaled by a master volume.
// One band term per channel is accumulated per clock, so a set takes
// NUM_BANDS cycles of accumulation plus one volume cycle.
//
// Gain/volume codes are unsigned; code 2^(GW-1) is unity gain, 0 is mute.
//
// Handshake: smpl_vld is a single-cycle "take this set" pulse with no ready
// signal. A pulse is accepted only when the FSM is IDLE (busy=0); a pulse
// seen while busy=1 is dropped and latches the sticky ovr flag. Results
// appear as a one-cycle out_vld strobe, and aud_out_* hold their value
// between strobes.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   smpl_vld          - new stereo band set present this cycle
//   lft_bands         - left band samples, band k at [k*DW +: DW] (signed)
//   rght_bands        - right band samples, same packing (signed)
//   POT               - per-band gains, band k at [k*GW +: GW] (unsigned)
//   VOLUME            - master volume (unsigned)
//   aud_out_lft/rght  - mixed output samples (signed)
//   out_vld           - one-cycle strobe, new aud_out_* valid
//   busy              - high while a set is being processed (state != IDLE)
//   ovr               - sticky overrun: a set arrived while busy
//
// Build option:
//   EQ_MIXER_SAT_EN   - when defined, the volume-scaled result clamps to the
//                       DW-bit signed range; otherwise it wraps (low DW bits).
// -----------------------------------------------------------------------------
module eq_mixer #(
    parameter int NUM_BANDS = 5,
    parameter int DW        = 16,
    parameter int GW        = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    smpl_vld,
    input  logic [NUM_BANDS*DW-1:0] lft_bands,
    input  logic [NUM_BANDS*DW-1:0] rght_bands,
    input  logic [NUM_BANDS*GW-1:0] POT,
    input  logic [GW-1:0]           VOLUME,
    output logic [DW-1:0]           aud_out_lft,
    output logic [DW-1:0]           aud_out_rght,
    output logic                    out_vld,
    output logic                    busy,
    output logic                    ovr
);

    localparam int KW = $clog2(NUM_BANDS);
    // Accumulator is wide enough for NUM_BANDS worst-case terms plus sign.
    localparam int AW = DW + GW + $clog2(NUM_BANDS) + 1;
    localparam int PW = DW + GW + 1;   // band * {0,POT} product width
    localparam int YW = AW + GW + 1;   // acc * {0,VOLUME} product width
    localparam logic [KW-1:0] LAST_K = KW'(NUM_BANDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        VOL   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [NUM_BANDS*DW-1:0] r_lft;
    logic [NUM_BANDS*DW-1:0] r_rght;
    logic [NUM_BANDS*GW-1:0] r_pot;
    logic [GW-1:0]           r_vol;
    logic [KW-1:0]           r_k;
    logic signed [AW-1:0]    r_acc_l;
    logic signed [AW-1:0]    r_acc_r;
    logic [DW-1:0]           r_out_l;
    logic [DW-1:0]           r_out_r;
    logic                    r_out_vld;
    logic                    r_ovr;

    logic signed [DW-1:0]    w_band_l;
    logic signed [DW-1:0]    w_band_r;
    logic [GW-1:0]           w_pot;
    logic signed [GW:0]      w_pot_s;
    logic signed [PW-1:0]    w_prod_l;
    logic signed [PW-1:0]    w_prod_r;
    logic signed [PW-1:0]    w_term_l;
    logic signed [PW-1:0]    w_term_r;
    logic signed [AW-1:0]    w_term_ext_l;
    logic signed [AW-1:0]    w_term_ext_r;
    logic signed [GW:0]      w_vol_s;
    logic signed [YW-1:0]    w_yfull_l;
    logic signed [YW-1:0]    w_yfull_r;
    logic signed [YW-1:0]    w_y_l;
    logic signed [YW-1:0]    w_y_r;
    logic [DW-1:0]           w_red_l;
    logic [DW-1:0]           w_red_r;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (smpl_vld) w_next = ACCUM;
            ACCUM:   if (r_k == LAST_K) w_next = VOL;
            VOL:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------- band select and per-band term ----------------
    always_comb begin
        w_band_l = '0;
        w_band_r = '0;
        w_pot    = '0;
        for (int i = 0; i < NUM_BANDS; i++) begin
            if (r_k == KW'(i)) begin
                w_band_l = r_lft[i*DW +: DW];
                w_band_r = r_rght[i*DW +: DW];
                w_pot    = r_pot[i*GW +: GW];
            end
        end
    end

    // Gains are unsigned; a zero MSB makes them non-negative signed operands.
    assign w_pot_s  = {1'b0, w_pot};
    assign w_prod_l = w_band_l * w_pot_s;
    assign w_prod_r = w_band_r * w_pot_s;
    // Arithmetic shift gives floor division by the unity code.
    assign w_term_l = w_prod_l >>> (GW - 1);
    assign w_term_r = w_prod_r >>> (GW - 1);
    assign w_term_ext_l = {{(AW - PW){w_term_l[PW-1]}}, w_term_l};
    assign w_term_ext_r = {{(AW - PW){w_term_r[PW-1]}}, w_term_r};

    // ---------------- volume scaling and output reduction ----------------
    assign w_vol_s   = {1'b0, r_vol};
    assign w_yfull_l = r_acc_l * w_vol_s;
    assign w_yfull_r = r_acc_r * w_vol_s;
    assign w_y_l     = w_yfull_l >>> (GW - 1);
    assign w_y_r     = w_yfull_r >>> (GW - 1);

`ifdef EQ_MIXER_SAT_EN
    localparam logic signed [YW-1:0] SAT_MAX = {{(YW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [YW-1:0] SAT_MIN = {{(YW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    always_comb begin
        w_red_l = w_y_l[DW-1:0];
        w_red_r = w_y_r[DW-1:0];
        if (w_y_l > SAT_MAX) w_red_l = SAT_MAX[DW-1:0];
        else if (w_y_l < SAT_MIN) w_red_l = SAT_MIN[DW-1:0];
        if (w_y_r > SAT_MAX) w_red_r = SAT_MAX[DW-1:0];
        else if (w_y_r < SAT_MIN) w_red_r = SAT_MIN[DW-1:0];
    end
`else
    logic w_unused_y;
    // Wrap mode keeps only the low DW bits; the upper bits are dropped on purpose.
    assign w_unused_y = ^{w_y_l[YW-1:DW], w_y_r[YW-1:DW]};
    assign w_red_l    = w_y_l[DW-1:0];
    assign w_red_r    = w_y_r[DW-1:0];
`endif

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lft     <= '0;
            r_rght    <= '0;
            r_pot     <= '0;
            r_vol     <= '0;
            r_k       <= '0;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_out_l   <= '0;
            r_out_r   <= '0;
            r_out_vld <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_out_vld <= 1'b0;
            // A set arriving mid-computation is dropped; only the flag records it.
            if (smpl_vld && (r_state != IDLE)) begin
                r_ovr <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (smpl_vld) begin
                        r_lft   <= lft_bands;
                        r_rght  <= rght_bands;
                        r_pot   <= POT;
                        r_vol   <= VOLUME;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                        r_k     <= '0;
                    end
                end
                ACCUM: begin
                    r_acc_l <= r_acc_l + w_term_ext_l;
                    r_acc_r <= r_acc_r + w_term_ext_r;
                    // Wrap k on the last band so it never indexes past NUM_BANDS-1.
                    if (r_k == LAST_K) r_k <= '0;
                    else               r_k <= r_k + KW'(1);
                end
                VOL: begin
                    r_out_l   <= w_red_l;
                    r_out_r   <= w_red_r;
                    r_out_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign aud_out_lft  = r_out_l;
    assign aud_out_rght = r_out_r;
    assign out_vld      = r_out_vld;
    assign busy         = (r_state != IDLE);
    assign ovr          = r_ovr;

endmodule

// File: doc/eq_mixer.md
EQ_MIXER -- requirements
Module: eq_mixer

Interface
REQ-001 SHALL have parameter NUM_BANDS, default 5, number of EQ bands summed per channel (2..16).
REQ-002 SHALL have parameter DW, default 16, audio sample width (signed two's complement).
REQ-003 SHALL have parameter GW, default 12, band-gain and volume pot width (unsigned).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port smpl_vld  input  1  new stereo band set present this cycle.
REQ-007 SHALL have port lft_bands  input  NUM_BANDS*DW  left band samples, band k at bits [k*DW +: DW].
REQ-008 SHALL have port rght_bands  input  NUM_BANDS*DW  right band samples, same packing.
REQ-009 SHALL have port POT  input  NUM_BANDS*GW  per-band gain, band k at bits [k*GW +: GW].
REQ-010 SHALL have port VOLUME  input  GW  master volume.
REQ-011 SHALL have port aud_out_lft  output  DW  mixed left sample.
REQ-012 SHALL have port aud_out_rght  output  DW  mixed right sample.
REQ-013 SHALL have port out_vld  output  1  one-cycle strobe, new aud_out_* valid.
REQ-014 SHALL have port busy  output  1  high while a band set is being processed.
REQ-015 SHALL have port ovr  output  1  sticky overrun flag.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, VOL; busy = (state != IDLE).
REQ-017 In IDLE with smpl_vld=1, SHALL register lft_bands, rght_bands, POT, VOLUME, clear both accumulators, set band index k=0, go to ACCUM.
REQ-018 Each ACCUM cycle SHALL add term_k = (band_k * {1'b0,POT_k}) >>> (GW-1) to each channel accumulator (signed, arithmetic shift, floor), then increment k.
REQ-019 Accumulator width SHALL be DW+GW+clog2(NUM_BANDS)+1 so no intermediate overflow occurs.
REQ-020 After term NUM_BANDS-1 is added, SHALL go to VOL; no other exit from ACCUM except reset.
REQ-021 In VOL SHALL compute y = (acc * {1'b0,VOLUME}) >>> (GW-1), reduce y to DW bits per REQ-031, register into aud_out_*, assert out_vld, return to IDLE.
REQ-022 Gain/volume code 2^(GW-1) (0x800 at GW=12) SHALL be unity; 0 SHALL yield 0.
REQ-023 out_vld SHALL be high for exactly one cycle, NUM_BANDS+1 cycles after the edge that accepted smpl_vld (6 at default).
REQ-024 aud_out_* SHALL hold value between out_vld strobes.
REQ-025 smpl_vld while busy=1 SHALL be dropped, SHALL set ovr, SHALL not disturb the running computation.
REQ-026 smpl_vld in the out_vld cycle (state IDLE) SHALL be accepted; sustained throughput one set per NUM_BANDS+1 cycles.
REQ-027 Left and right channels SHALL be computed in parallel, identical timing.

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE, k=0, accumulators 0, aud_out_lft=0, aud_out_rght=0, out_vld=0, ovr=0.
REQ-029 Reset during ACCUM or VOL SHALL abort the set; no out_vld for it.
REQ-030 smpl_vld in a cycle with rst=1 SHALL be ignored.

Configuration
REQ-031 With EQ_MIXER_SAT_EN defined, y SHALL clamp to [-2^(DW-1), 2^(DW-1)-1]; without it, y SHALL be truncated to its low DW bits (wrap).

Verification (NUM_BANDS=5, DW=16, GW=12)
REQ-032 All bands L=0x0100, R=0xFF00, POT all 0x800, VOLUME 0x800 -> out_vld 6 cycles later, L=0x0500, R=0xFB00.
REQ-033 All bands L=0x4000, R=0xC000, POT all 0xFFF, VOLUME 0x800 -> SAT_EN: L=0x7FFF, R=0x8000; no SAT_EN: L=0x7FD8, R=0x8028.
REQ-034 smpl_vld at cycles 0 and 3 -> single out_vld at cycle 6 with set-0 result, ovr=1 until rst.
REQ-035 smpl_vld at cycle 0 and again in out_vld cycle 6 -> both accepted, out_vld at cycles 6 and 12.
REQ-036 rst pulsed at cycle 3 after smpl_vld at cycle 0 -> no out_vld, aud_out_*=0x0000, busy=0 from cycle 4.
REQ-037 Bands 0x1234, POT 0x800, VOLUME 0x000 -> out_vld at cycle 6 with L=R=0x0000.
